// File: rtl/serial_tx_bit_sequencer.sv
// Bit-timing sequencer for the serial transmitter: frames one character per start
// request, driving the output-bit select, shift strobes, mode-0 shift clock and end pulse.
//
// state   | meaning
// IDLE    | line at mark, waiting for a start request
// START   | start bit on the line (modes 1-3)
// DATA    | shifter LSB on the line, data bits 1-8 plus TB8 in modes 2/3
// STOP    | stop bit on the line, last bit of the frame
// M0_DATA | mode-0 synchronous data bits 0-7 with generated shift clock
module serial_tx_bit_sequencer #(
  parameter int TICKS_PER_BIT   = 16,
  parameter int M0_CLKS_PER_BIT = 12
) (
  input  logic       serial_clock_i,
  input  logic       serial_reset_i_b,
  input  logic       serial_br_i,
  input  logic       serial_scon7_sm0_i,
  input  logic       serial_scon6_sm1_i,
  input  logic       serial_start_i,
  output logic       serial_busy_o,
  output logic [1:0] serial_tx_sel_o,
  output logic       serial_shift_o,
  output logic [3:0] serial_bit_idx_o,
  output logic       serial_shift_clk_o,
  output logic       serial_end_bit_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_M0_DATA = 3'd4
  } state_t;

  localparam int CNT_MAX = (TICKS_PER_BIT > M0_CLKS_PER_BIT) ? TICKS_PER_BIT : M0_CLKS_PER_BIT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_BIT - 1);
  localparam logic [CW-1:0] M0_LAST   = CW'(M0_CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] M0_HALF   = CW'(M0_CLKS_PER_BIT / 2);

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q;
  logic          shift_q, shift_d;
  logic          end_q, end_d;

  logic          tick;
  logic [3:0]    last_data_idx;
  logic [1:0]    req_mode;

  assign tick          = serial_br_i & ~br_q;
  assign req_mode      = {serial_scon7_sm0_i, serial_scon6_sm1_i};
  // Mode 1 has no TB8, so its data phase ends one bit earlier.
  assign last_data_idx = (mode_q == 2'b01) ? 4'd8 : 4'd9;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    shift_d   = 1'b0;
    end_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (serial_start_i) begin
          mode_d    = req_mode;
          bit_idx_d = 4'd0;
          cnt_d     = '0;
          state_d   = (req_mode == 2'b00) ? ST_M0_DATA : ST_START;
        end
      end

      ST_START, ST_DATA, ST_STOP: begin
        if (tick) begin
          if (cnt_q == TICK_LAST) begin
            cnt_d = '0;
            if (state_q == ST_START) begin
              state_d   = ST_DATA;
              bit_idx_d = bit_idx_q + 4'd1;
            end else if (state_q == ST_DATA) begin
              shift_d   = 1'b1;
              bit_idx_d = bit_idx_q + 4'd1;
              if (bit_idx_q == last_data_idx) begin
                state_d = ST_STOP;
              end
            end else begin
              state_d   = ST_IDLE;
              bit_idx_d = 4'd0;
              end_d     = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_M0_DATA: begin
        if (cnt_q == M0_LAST) begin
          cnt_d   = '0;
          shift_d = 1'b1;
          if (bit_idx_q == 4'd7) begin
            state_d   = ST_IDLE;
            bit_idx_d = 4'd0;
            end_d     = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_idx_d = 4'd0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      state_q   <= ST_IDLE;
      mode_q    <= 2'b00;
      bit_idx_q <= 4'd0;
      cnt_q     <= '0;
      br_q      <= 1'b0;
      shift_q   <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      br_q      <= serial_br_i;
      shift_q   <= shift_d;
      end_q     <= end_d;
    end
  end

  always_comb begin
    serial_tx_sel_o = 2'b00;
    case (state_q)
      ST_START:             serial_tx_sel_o = 2'b01;
      ST_DATA, ST_M0_DATA:  serial_tx_sel_o = 2'b10;
      ST_STOP:              serial_tx_sel_o = 2'b11;
      default:              serial_tx_sel_o = 2'b00;
    endcase
  end

  assign serial_busy_o      = (state_q != ST_IDLE);
  assign serial_shift_o     = shift_q;
  assign serial_end_bit_o   = end_q;
  assign serial_bit_idx_o   = bit_idx_q;
  // Low for the first half of each mode-0 bit period, idle high otherwise.
  assign serial_shift_clk_o = ~((state_q == ST_M0_DATA) && (cnt_q < M0_HALF));

endmodule

// File: tb/tb_serial_tx_bit_sequencer.sv
// Directed self-checking bench for serial_tx_bit_sequencer: modes 0/1/2 frames,
// ignored restart/mode change, mid-frame reset and back-to-back frames.
module tb_serial_tx_bit_sequencer;

  logic       clk;
  logic       rst_b;
  logic       br;
  logic       sm0, sm1;
  logic       start;
  logic       busy;
  logic [1:0] tx_sel;
  logic       shift;
  logic [3:0] bit_idx;
  logic       shift_clk;
  logic       end_bit;

  int n_checks = 0;
  int n_errors = 0;

  int br_en    = 0;
  int ph       = 0;
  int br_rises = 0;

  int sel_seq[$];

  serial_tx_bit_sequencer #(.TICKS_PER_BIT(16), .M0_CLKS_PER_BIT(12)) dut (
    .serial_clock_i     (clk),
    .serial_reset_i_b   (rst_b),
    .serial_br_i        (br),
    .serial_scon7_sm0_i (sm0),
    .serial_scon6_sm1_i (sm1),
    .serial_start_i     (start),
    .serial_busy_o      (busy),
    .serial_tx_sel_o    (tx_sel),
    .serial_shift_o     (shift),
    .serial_bit_idx_o   (bit_idx),
    .serial_shift_clk_o (shift_clk),
    .serial_end_bit_o   (end_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud level: period 32 clocks, rising at phase 16.
  always @(negedge clk) begin
    if (br_en != 0) begin
      ph = (ph == 31) ? 0 : ph + 1;
      if (ph == 16) begin
        br = 1'b1;
        br_rises++;
      end else if (ph == 0) begin
        br = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; aligned starts sit well away from a baud rise.
  task automatic do_start(input bit aligned);
    int guard;
    guard = 0;
    @(negedge clk);
    if (aligned) begin
      while (ph != 4 && guard < 64) begin
        @(negedge clk);
        guard++;
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes one frame starting at the first negedge after the accept edge (c = 0).
  // inject: 0 none, 1 restart + mode change at bit 4, 2 reset at bit 5.
  task automatic run_frame(input int budget, input int inject, input bit m0,
                           output int shifts, output int ends, output int end_c,
                           output int ticks, output int stop_idx, output int max_didx,
                           output int busy_at_end, output int busy_err,
                           output int pos_err, output int clk_err);
    int  c;
    int  prev_sel;
    int  rise0;
    bit  done;
    bit  inj_done;
    c = 0; prev_sel = -1; rise0 = br_rises; done = 0; inj_done = 0;
    shifts = 0; ends = 0; end_c = -1; ticks = 0; stop_idx = -1; max_didx = -1;
    busy_at_end = -1; busy_err = 0; pos_err = 0; clk_err = 0;
    sel_seq.delete();
    while (!done && c <= budget) begin
      start = 1'b0;
      if (int'(tx_sel) != prev_sel) begin
        sel_seq.push_back(int'(tx_sel));
        prev_sel = int'(tx_sel);
      end
      if (shift) begin
        shifts++;
        if (m0 && !((c % 12) == 0 && c > 0)) pos_err++;
      end
      if (m0 && c < 96 && shift_clk !== ((c % 12) >= 6)) clk_err++;
      if (tx_sel == 2'b11) stop_idx = int'(bit_idx);
      if (tx_sel == 2'b10 && int'(bit_idx) > max_didx) max_didx = int'(bit_idx);
      if (end_bit) begin
        ends++;
        end_c = c;
        busy_at_end = int'(busy);
        ticks = br_rises - rise0;
        done = 1;
      end else if (!busy) begin
        busy_err++;
      end
      if (!done && inject == 1 && !inj_done && bit_idx == 4'd4) begin
        start = 1'b1;
        sm0 = 1'b1;
        sm1 = 1'b0;
        inj_done = 1;
      end
      if (!done && inject == 2 && !inj_done && bit_idx == 4'd5) begin
        rst_b = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_sel", tx_sel, 0);
        check("rst_mid_shift", shift, 0);
        check("rst_mid_idx", bit_idx, 0);
        check("rst_mid_sclk", shift_clk, 1);
        check("rst_mid_end", end_bit, 0);
        inj_done = 1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (end_bit) ends++;
        end
        rst_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (end_bit) ends++;
        end
        done = 1;
      end
      if (!done) begin
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    if (!done) check("frame_timeout", 0, 1);
  endtask

  int shifts, ends, end_c, ticks, stop_idx, max_didx, busy_at_end, busy_err, pos_err, clk_err;
  int first_shifts, first_ticks;

  initial begin
    rst_b = 1'b0; br = 1'b0; sm0 = 1'b0; sm1 = 1'b0; start = 1'b0;
    br_en = 1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_sel", tx_sel, 0);
    check("rst_shift", shift, 0);
    check("rst_idx", bit_idx, 0);
    check("rst_sclk", shift_clk, 1);
    check("rst_end", end_bit, 0);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 1
    sm0 = 1'b0; sm1 = 1'b1;
    do_start(1);
    run_frame(6000, 0, 0, shifts, ends, end_c, ticks, stop_idx, max_didx,
              busy_at_end, busy_err, pos_err, clk_err);
    check("m1_shifts", shifts, 8);
    check("m1_ends", ends, 1);
    check("m1_ticks", ticks, 160);
    check("m1_busy_at_end", busy_at_end, 0);
    check("m1_busy_err", busy_err, 0);
    check("m1_stop_idx", stop_idx, 9);
    check("m1_max_data_idx", max_didx, 8);
    check("m1_seq_len", sel_seq.size(), 4);
    if (sel_seq.size() == 4) begin
      check("m1_seq0", sel_seq[0], 1);
      check("m1_seq1", sel_seq[1], 2);
      check("m1_seq2", sel_seq[2], 3);
      check("m1_seq3", sel_seq[3], 0);
    end
    @(negedge clk);
    check("m1_end_one_cycle", end_bit, 0);

    // Mode 2
    sm0 = 1'b1; sm1 = 1'b0;
    do_start(1);
    run_frame(6000, 0, 0, shifts, ends, end_c, ticks, stop_idx, max_didx,
              busy_at_end, busy_err, pos_err, clk_err);
    check("m2_shifts", shifts, 9);
    check("m2_ends", ends, 1);
    check("m2_ticks", ticks, 176);
    check("m2_stop_idx", stop_idx, 10);
    check("m2_max_data_idx", max_didx, 9);
    check("m2_busy_at_end", busy_at_end, 0);

    // Mode 0, baud keeps toggling
    sm0 = 1'b0; sm1 = 1'b0;
    do_start(1);
    run_frame(200, 0, 1, shifts, ends, end_c, ticks, stop_idx, max_didx,
              busy_at_end, busy_err, pos_err, clk_err);
    check("m0_shifts", shifts, 8);
    check("m0_ends", ends, 1);
    check("m0_end_clock", end_c, 96);
    check("m0_shift_pos_err", pos_err, 0);
    check("m0_sclk_err", clk_err, 0);
    check("m0_busy_at_end", busy_at_end, 0);
    check("m0_max_idx", max_didx, 7);
    check("m0_seq_len", sel_seq.size(), 2);
    @(negedge clk);
    check("m0_sclk_idle", shift_clk, 1);

    // Mode 1 with restart and mode change mid-frame
    sm0 = 1'b0; sm1 = 1'b1;
    do_start(1);
    run_frame(6000, 1, 0, shifts, ends, end_c, ticks, stop_idx, max_didx,
              busy_at_end, busy_err, pos_err, clk_err);
    check("ign_shifts", shifts, 8);
    check("ign_ticks", ticks, 160);
    check("ign_stop_idx", stop_idx, 9);
    check("ign_ends", ends, 1);

    // Mode 2 reset at bit 5, then a full frame
    sm0 = 1'b1; sm1 = 1'b0;
    do_start(1);
    run_frame(6000, 2, 0, shifts, ends, end_c, ticks, stop_idx, max_didx,
              busy_at_end, busy_err, pos_err, clk_err);
    check("rst_no_end", ends, 0);
    check("rst_idle_busy", busy, 0);
    do_start(1);
    run_frame(6000, 0, 0, shifts, ends, end_c, ticks, stop_idx, max_didx,
              busy_at_end, busy_err, pos_err, clk_err);
    check("post_rst_shifts", shifts, 9);
    check("post_rst_ticks", ticks, 176);
    check("post_rst_stop_idx", stop_idx, 10);

    // Mode 1 back-to-back frames
    sm0 = 1'b0; sm1 = 1'b1;
    do_start(1);
    run_frame(6000, 0, 0, shifts, ends, end_c, ticks, stop_idx, max_didx,
              busy_at_end, busy_err, pos_err, clk_err);
    first_shifts = shifts;
    first_ticks  = ticks;
    check("b2b_first_shifts", first_shifts, 8);
    do_start(0);
    check("b2b_accept_busy", busy, 1);
    check("b2b_accept_sel", tx_sel, 1);
    run_frame(6000, 0, 0, shifts, ends, end_c, ticks, stop_idx, max_didx,
              busy_at_end, busy_err, pos_err, clk_err);
    check("b2b_second_shifts", shifts, 8);
    check("b2b_second_ticks", ticks, 160);
    check("b2b_second_ends", ends, 1);
    check("b2b_first_ticks", first_ticks, 160);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
